netdma_report_arbiter: RTL and testbench

Merges the 32-bit report words from the read (tx) and write (rx) control channels into the single host-facing report FIFO. Each channel raises its report as a one-cycle word with the is_report bit set and cannot be stalled. The block therefore buffers reports per channel and round-robin schedules them into the shared FIFO. It also generates the host report interrupt and flags dropped reports.

---
 rtl/netdma_report_arbiter_if.sv | 24 ++
 rtl/netdma_report_arbiter.sv | 141 ++++++++++++++
 tb/tb_netdma_report_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/netdma_report_arbiter_if.sv
// Host report FIFO write port: one report word plus its source channel,
// a one-cycle write strobe, and the FIFO's almost-full back-pressure.
interface netdma_report_arbiter_if;
  logic [31:0] report_data;
  logic        report_src;
  logic        report_wrreq;
  logic        report_full;

  // Arbiter side: produces writes, observes almost-full.
  modport master (
    output report_data,
    output report_src,
    output report_wrreq,
    input  report_full
  );

  // Host FIFO side: consumes writes, drives almost-full.
  modport slave (
    input  report_data,
    input  report_src,
    input  report_wrreq,
    output report_full
  );
endinterface

// File: rtl/netdma_report_arbiter.sv
// Report merger: buffers the unstallable tx/rx report words in per-channel
// FIFOs, round-robin drains them into the host report FIFO, raises the
// host report interrupt and flags reports dropped on buffer overflow.
// Channel index 0 is tx, 1 is rx throughout.
module netdma_report_arbiter #(
  parameter  int SKID_DEPTH      = 4,
  parameter  int IS_REPORT_BIT   = 31,
  parameter  int DISABLE_IRQ_BIT = 30,
  localparam int LW              = $clog2(SKID_DEPTH) + 1,
  localparam int PW              = $clog2(SKID_DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              tx_report_i,
  input  logic [31:0]              rx_report_i,
  netdma_report_arbiter_if.master  report_io,
  output logic [LW-1:0]            tx_level_o,
  output logic [LW-1:0]            rx_level_o,
  output logic                     tx_ovf_o,
  output logic                     rx_ovf_o,
  input  logic                     ovf_clr_i,
  output logic                     irq_o,
  input  logic                     irq_ack_i
);

  logic [31:0]   mem_q     [2][SKID_DEPTH];
  logic [PW-1:0] wr_ptr_q  [2];
  logic [PW-1:0] wr_ptr_d  [2];
  logic [PW-1:0] rd_ptr_q  [2];
  logic [PW-1:0] rd_ptr_d  [2];
  logic [LW-1:0] lvl_q     [2];
  logic [LW-1:0] lvl_d     [2];
  logic [1:0]    ovf_q, ovf_d;
  logic          last_grant_q, last_grant_d;
  logic [31:0]   data_q, data_d;
  logic          src_q, src_d;
  logic          wrreq_q, wrreq_d;
  logic          irq_q, irq_d;

  logic [31:0]   in_word [2];
  logic [1:0]    push, nonempty, full, pop, accept, drop;
  logic          grant_vld, grant_ch;

  // Capture decode, round-robin grant, FIFO bookkeeping and output next-state.
  always_comb begin
    in_word[0] = tx_report_i;
    in_word[1] = rx_report_i;
    for (int c = 0; c < 2; c++) begin
      push[c]     = in_word[c][IS_REPORT_BIT];
      nonempty[c] = (lvl_q[c] != '0);
      full[c]     = (lvl_q[c] == LW'(SKID_DEPTH));
    end

    // Under contention the channel that did not win last time goes next.
    grant_vld = 1'b0;
    grant_ch  = 1'b0;
    if (!report_io.report_full) begin
      if (nonempty[0] && nonempty[1]) begin
        grant_vld = 1'b1;
        grant_ch  = ~last_grant_q;
      end else if (nonempty[0]) begin
        grant_vld = 1'b1;
        grant_ch  = 1'b0;
      end else if (nonempty[1]) begin
        grant_vld = 1'b1;
        grant_ch  = 1'b1;
      end
    end

    pop = 2'b00;
    if (grant_vld) pop[grant_ch] = 1'b1;

    // A full FIFO still accepts a push when it pops in the same cycle.
    for (int c = 0; c < 2; c++) begin
      accept[c]   = push[c] & (~full[c] | pop[c]);
      drop[c]     = push[c] & full[c] & ~pop[c];
      wr_ptr_d[c] = accept[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
      rd_ptr_d[c] = pop[c]    ? rd_ptr_q[c] + PW'(1) : rd_ptr_q[c];
      case ({accept[c], pop[c]})
        2'b10:   lvl_d[c] = lvl_q[c] + LW'(1);
        2'b01:   lvl_d[c] = lvl_q[c] - LW'(1);
        default: lvl_d[c] = lvl_q[c];
      endcase
      // A drop in the clear cycle keeps the flag set.
      ovf_d[c] = drop[c] | (ovf_q[c] & ~ovf_clr_i);
    end

    last_grant_d = grant_vld ? grant_ch : last_grant_q;
    wrreq_d      = grant_vld;
    data_d       = grant_vld ? mem_q[grant_ch][rd_ptr_q[grant_ch]] : data_q;
    src_d        = grant_vld ? grant_ch : src_q;
    // Set from the write cycle takes priority over a same-cycle acknowledge.
    irq_d        = (wrreq_q & ~data_q[DISABLE_IRQ_BIT]) | (irq_q & ~irq_ack_i);
  end

  // Report storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < 2; c++) begin
      if (accept[c]) mem_q[c][wr_ptr_q[c]] <= in_word[c];
    end
  end

  // Control and output registers; reset flushes both buffers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        lvl_q[c]    <= '0;
      end
      ovf_q        <= 2'b00;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      src_q        <= 1'b0;
      wrreq_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        lvl_q[c]    <= lvl_d[c];
      end
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      src_q        <= src_d;
      wrreq_q      <= wrreq_d;
      irq_q        <= irq_d;
    end
  end

  assign report_io.report_data  = data_q;
  assign report_io.report_src   = src_q;
  assign report_io.report_wrreq = wrreq_q;
  assign tx_level_o             = lvl_q[0];
  assign rx_level_o             = lvl_q[1];
  assign tx_ovf_o               = ovf_q[0];
  assign rx_ovf_o               = ovf_q[1];
  assign irq_o                  = irq_q;

endmodule

// File: tb/tb_netdma_report_arbiter.sv
// Bench for netdma_report_arbiter: scenario tasks drive reports and check
// timing/flags inline; a negedge monitor pops the expected-write queue.
module tb_netdma_report_arbiter;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   tx_rep = '0;
  logic [31:0]   rx_rep = '0;
  logic          ovf_clr = 1'b0;
  logic          irq_ack = 1'b0;
  logic [LW-1:0] tx_level, rx_level;
  logic          tx_ovf, rx_ovf, irq;

  int total = 0;
  int bad = 0;
  int nwrites = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_w;

  always #5 clk = ~clk;

  netdma_report_arbiter_if rif();

  netdma_report_arbiter #(.SKID_DEPTH(D), .IS_REPORT_BIT(31), .DISABLE_IRQ_BIT(30)) dut (
    .clk_i(clk), .rst_i(rst),
    .tx_report_i(tx_rep), .rx_report_i(rx_rep),
    .report_io(rif.master),
    .tx_level_o(tx_level), .rx_level_o(rx_level),
    .tx_ovf_o(tx_ovf), .rx_ovf_o(rx_ovf),
    .ovf_clr_i(ovf_clr),
    .irq_o(irq), .irq_ack_i(irq_ack)
  );

  // Every host write must match the oldest expected {src, data}.
  always @(negedge clk) begin
    if (rif.report_wrreq === 1'b1) begin
      nwrites++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got src=%0d data=%h, none expected", rif.report_src, rif.report_data);
      end else begin
        exp_w = sb.pop_front();
        if ({rif.report_src, rif.report_data} !== exp_w) begin
          bad++;
          $display("FAIL write_order got src=%0d data=%h exp src=%0d data=%h",
                   rif.report_src, rif.report_data, exp_w[32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick;
    end
    tick;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rif.report_full = 1'b0;
    tick;
    total++;
    if (rif.report_data !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=%h", rif.report_data, 32'h0);
    end
    total++;
    if ({tx_level, rx_level} !== '0) begin
      bad++; $display("FAIL reset_levels got tx=%0d rx=%0d exp 0/0", tx_level, rx_level);
    end
    total++;
    if ({rif.report_src, rif.report_wrreq, tx_ovf, rx_ovf, irq} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got src/wrreq/txovf/rxovf/irq=%b exp=00000",
                      {rif.report_src, rif.report_wrreq, tx_ovf, rx_ovf, irq});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    tx_rep = 32'h8000_0005;
    sb.push_back({1'b0, 32'h8000_0005});
    tick;
    tx_rep = '0;
    total++;
    if (rif.report_wrreq !== 1'b0) begin
      bad++; $display("FAIL single_early got wrreq=%b exp=0", rif.report_wrreq);
    end
    total++;
    if (tx_level !== 3'd1) begin
      bad++; $display("FAIL single_level got=%0d exp=1", tx_level);
    end
    tick;
    total++;
    if ({rif.report_wrreq, rif.report_src, rif.report_data} !== {1'b1, 1'b0, 32'h8000_0005}) begin
      bad++; $display("FAIL single_latency got wrreq=%b src=%0d data=%h exp 1/0/80000005",
                      rif.report_wrreq, rif.report_src, rif.report_data);
    end
    tick;
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL single_irq_set got=%b exp=1", irq);
    end
    tick;
    irq_ack = 1'b1;
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL single_irq_hold got=%b exp=1", irq);
    end
    tick;
    irq_ack = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL single_irq_ack got=%b exp=0", irq);
    end
    wait_drain(10);
  endtask

  task automatic test_contention;
    int tx_peak, rx_peak, w0;
    do_reset;
    tx_peak = 0;
    rx_peak = 0;
    w0 = nwrites;
    for (int i = 0; i < 4; i++) begin
      tx_rep = 32'h8000_1000 + i;
      rx_rep = 32'h8000_2000 + i;
      sb.push_back({1'b0, 32'h8000_1000 + i});
      sb.push_back({1'b1, 32'h8000_2000 + i});
      tick;
      if (int'(tx_level) > tx_peak) tx_peak = int'(tx_level);
      if (int'(rx_level) > rx_peak) rx_peak = int'(rx_level);
    end
    tx_rep = '0;
    rx_rep = '0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (int'(tx_level) > tx_peak) tx_peak = int'(tx_level);
      if (int'(rx_level) > rx_peak) rx_peak = int'(rx_level);
    end
    // 8 pushes in 4 cycles against one pop per cycle from the second cycle:
    // tx peaks at 2, rx (granted second) peaks at 3.
    total++;
    if (tx_peak != 2 || rx_peak != 3) begin
      bad++; $display("FAIL contention_peak got tx=%0d rx=%0d exp tx=2 rx=3", tx_peak, rx_peak);
    end
    total++;
    if (nwrites - w0 != 8 || sb.size() != 0) begin
      bad++; $display("FAIL contention_count got writes=%0d left=%0d exp 8/0", nwrites - w0, sb.size());
    end
  endtask

  task automatic test_full_ovf;
    int w0;
    w0 = nwrites;
    rif.report_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_rep = 32'h8000_3000 + i;
      sb.push_back({1'b1, 32'h8000_3000 + i});
      tick;
      total++;
      if (rif.report_wrreq !== 1'b0) begin
        bad++; $display("FAIL full_nowrite got wrreq=%b exp=0", rif.report_wrreq);
      end
    end
    total++;
    if (rx_level !== 3'd4 || rx_ovf !== 1'b0) begin
      bad++; $display("FAIL full_level got lvl=%0d ovf=%b exp 4/0", rx_level, rx_ovf);
    end
    rx_rep = 32'h8000_30FF;
    tick;
    rx_rep = '0;
    total++;
    if (rx_level !== 3'd4 || rx_ovf !== 1'b1 || tx_ovf !== 1'b0) begin
      bad++; $display("FAIL full_drop got lvl=%0d rxovf=%b txovf=%b exp 4/1/0", rx_level, rx_ovf, tx_ovf);
    end
    ovf_clr = 1'b1;
    rx_rep = 32'h8000_30FE;
    tick;
    ovf_clr = 1'b0;
    rx_rep = '0;
    total++;
    if (rx_ovf !== 1'b1) begin
      bad++; $display("FAIL clr_vs_drop got=%b exp=1", rx_ovf);
    end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    total++;
    if (rx_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=0", rx_ovf);
    end
    rif.report_full = 1'b0;
    wait_drain(20);
    total++;
    if (nwrites - w0 != 4 || sb.size() != 0) begin
      bad++; $display("FAIL full_release got writes=%0d left=%0d exp 4/0", nwrites - w0, sb.size());
    end
  endtask

  task automatic test_disable_irq;
    int w0;
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    w0 = nwrites;
    rx_rep = 32'hC000_0100;
    sb.push_back({1'b1, 32'hC000_0100});
    tick;
    rx_rep = '0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (irq !== 1'b0) begin
        bad++; $display("FAIL noirq got=%b exp=0", irq);
      end
    end
    total++;
    if (nwrites - w0 != 1) begin
      bad++; $display("FAIL noirq_write got writes=%0d exp=1", nwrites - w0);
    end
  endtask

  task automatic test_push_pop_full;
    rif.report_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_rep = 32'h8000_4000 + i;
      sb.push_back({1'b1, 32'h8000_4000 + i});
      tick;
    end
    rif.report_full = 1'b0;
    rx_rep = 32'h8000_4004;
    sb.push_back({1'b1, 32'h8000_4004});
    tick;
    rx_rep = '0;
    total++;
    if (rx_level !== 3'd4 || rx_ovf !== 1'b0) begin
      bad++; $display("FAIL pushpop_full got lvl=%0d ovf=%b exp 4/0", rx_level, rx_ovf);
    end
    wait_drain(20);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL pushpop_drain got left=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    rif.report_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_rep = 32'h8000_5000 + i;
      tick;
    end
    tx_rep = '0;
    total++;
    if (tx_level !== 3'd3) begin
      bad++; $display("FAIL mid_level got=%0d exp=3", tx_level);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({rif.report_data, rif.report_src, rif.report_wrreq, tx_ovf, rx_ovf, irq} !== 37'h0 ||
        {tx_level, rx_level} !== '0) begin
      bad++; $display("FAIL mid_async_reset got data=%h src=%b wr=%b irq=%b tx=%0d rx=%0d exp all 0",
                      rif.report_data, rif.report_src, rif.report_wrreq, irq, tx_level, rx_level);
    end
    tick;
    tick;
    rst = 1'b0;
    rif.report_full = 1'b0;
    w0 = nwrites;
    tx_rep = 32'h8000_5555;
    sb.push_back({1'b0, 32'h8000_5555});
    tick;
    tx_rep = '0;
    tick;
    total++;
    if ({rif.report_wrreq, rif.report_data} !== {1'b1, 32'h8000_5555}) begin
      bad++; $display("FAIL mid_after got wrreq=%b data=%h exp 1/80005555", rif.report_wrreq, rif.report_data);
    end
    wait_drain(10);
    total++;
    if (nwrites - w0 != 1) begin
      bad++; $display("FAIL mid_stale got writes=%0d exp=1", nwrites - w0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_full_ovf;
    test_disable_irq;
    test_push_pop_full;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
